// File: rtl/vc_sel_arbiter_pkg.sv
// Shared constants and state encoding for the per-input-port VC select arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package vc_sel_arbiter_pkg;

  localparam int NUM_PORT       = 5;
  localparam int NUM_VC         = 6;
  localparam int VC_INDEX_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

endpackage

// File: rtl/vc_sel_arbiter_rr_pick_vc.sv
// Wrap-around priority pick: first candidate at or above i_start, modulo NUM_VC.
// Latency: combinational.
// Backpressure: none; o_found=0 when no candidate survives the exclude mask.
// Ports: i_valid (candidates), i_start (search origin, < NUM_VC), i_excl (mask of
//        indices to skip), o_idx (chosen index), o_found (any candidate found).
module rr_pick_vc #(
  parameter int NUM_VC         = 6,
  parameter int VC_INDEX_WIDTH = 3
) (
  input  logic [NUM_VC-1:0]         i_valid,
  input  logic [VC_INDEX_WIDTH-1:0] i_start,
  input  logic [NUM_VC-1:0]         i_excl,
  output logic [VC_INDEX_WIDTH-1:0] o_idx,
  output logic                      o_found
);

  logic [NUM_VC-1:0] w_cand;
  int                w_pos;

  assign w_cand = i_valid & ~i_excl;

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < NUM_VC; k++) begin
      w_pos = int'(i_start) + k;
      if (w_pos >= NUM_VC) begin
        w_pos = w_pos - NUM_VC;
      end
      if (!o_found && w_cand[w_pos]) begin
        o_found = 1'b1;
        o_idx   = VC_INDEX_WIDTH'(w_pos);
      end
    end
  end

endmodule

// File: rtl/vc_sel_arbiter.sv
// Per-input-port VC scheduler driving the select of the per-VC request mux.
// Latency: request to sel_valid in 1 cycle; sel is registered, pop/sel_valid combinational.
// Backpressure: sel is held until sa_grant; a VC starved for MAX_WAIT cycles is rotated away.
// Ports: clk, rst_n (async active-low); vc_req_valid/vc_is_tail per VC; sa_grant from
//        the switch allocator; sel/sel_valid to the mux; vc_pop one-hot dequeue; locked.
module vc_sel_arbiter
  import vc_sel_arbiter_pkg::*;
#(
  parameter int NUM_VC         = 6,
  parameter int VC_INDEX_WIDTH = 3,
  parameter int LOCK_PKT       = 1,
  parameter int MAX_WAIT       = 8,
  parameter int WAIT_W         = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_VC-1:0]         vc_req_valid,
  input  logic [NUM_VC-1:0]         vc_is_tail,
  input  logic                      sa_grant,
  output logic [VC_INDEX_WIDTH-1:0] sel,
  output logic                      sel_valid,
  output logic [NUM_VC-1:0]         vc_pop,
  output logic                      locked
);

  localparam int WAIT_LAST = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;

  state_e                    r_state,    w_state_nxt;
  logic [VC_INDEX_WIDTH-1:0] r_sel,      w_sel_nxt;
  logic [VC_INDEX_WIDTH-1:0] r_rr_ptr,   w_rr_ptr_nxt;
  logic [WAIT_W-1:0]         r_wait_cnt, w_wait_cnt_nxt;

  logic [NUM_VC-1:0]         w_sel_oh;
  logic [VC_INDEX_WIDTH-1:0] w_sel_inc;
  logic                      w_grant;
  logic                      w_tail;
  logic                      w_release;
  logic                      w_wait_last;
  logic [VC_INDEX_WIDTH-1:0] w_pick_start;
  logic [NUM_VC-1:0]         w_pick_excl;
  logic [VC_INDEX_WIDTH-1:0] w_pick_idx;
  logic                      w_pick_found;

  assign w_sel_oh  = {{(NUM_VC-1){1'b0}}, 1'b1} << r_sel;
  assign w_sel_inc = (r_sel == VC_INDEX_WIDTH'(NUM_VC - 1)) ? '0 : r_sel + VC_INDEX_WIDTH'(1);

  assign sel       = r_sel;
  assign sel_valid = (r_state != ST_IDLE) && ((vc_req_valid & w_sel_oh) != '0);
  assign w_grant   = sa_grant & sel_valid;
  assign vc_pop    = w_sel_oh & {NUM_VC{w_grant}};
  assign locked    = (r_state == ST_LOCK);

  assign w_tail      = |(vc_is_tail & w_sel_oh);
  assign w_wait_last = (r_wait_cnt == WAIT_W'(WAIT_LAST));

  // Packet boundary: the granted flit ends the packet (or locking is off), so
  // the VC is given up and the next candidate comes from after it.
  assign w_release = w_grant &&
                     (((r_state == ST_REQ) && (w_tail || (LOCK_PKT == 0))) ||
                      ((r_state == ST_LOCK) && w_tail));

  // From IDLE the search starts at rr_ptr with nothing excluded; otherwise it
  // starts just past sel and the current VC is excluded, so o_found also means
  // "some other VC is waiting".
  assign w_pick_start = (r_state == ST_IDLE) ? r_rr_ptr : w_sel_inc;
  assign w_pick_excl  = (r_state == ST_IDLE) ? '0 : w_sel_oh;

  rr_pick_vc #(
    .NUM_VC         (NUM_VC),
    .VC_INDEX_WIDTH (VC_INDEX_WIDTH)
  ) u_pick (
    .i_valid (vc_req_valid),
    .i_start (w_pick_start),
    .i_excl  (w_pick_excl),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_wait_cnt_nxt = r_wait_cnt;
    if (w_release) begin
      w_rr_ptr_nxt   = w_sel_inc;
      w_wait_cnt_nxt = '0;
      if (w_pick_found) begin
        w_sel_nxt   = w_pick_idx;
        w_state_nxt = ST_REQ;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|vc_req_valid) begin
            w_sel_nxt      = w_pick_idx;
            w_state_nxt    = ST_REQ;
            w_wait_cnt_nxt = '0;
          end
        end
        ST_REQ: begin
          if (w_grant) begin
            // Head/body flit granted: hold this VC for the rest of the packet.
            w_state_nxt    = ST_LOCK;
            w_wait_cnt_nxt = '0;
          end else if (sel_valid) begin
            if (MAX_WAIT != 0) begin
              if (!w_wait_last) begin
                w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
              end else if (w_pick_found) begin
                // Starved: move on without disturbing the fairness pointer.
                w_sel_nxt      = w_pick_idx;
                w_wait_cnt_nxt = '0;
              end
            end
          end else begin
            w_state_nxt    = ST_IDLE;
            w_wait_cnt_nxt = '0;
          end
        end
        ST_LOCK: begin
          // Bubbles and non-tail grants keep the lock; tail grants release above.
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_rr_ptr   <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_vc_sel_arbiter.sv
module tb_vc_sel_arbiter;

  logic       clk;
  logic       rst_n;
  logic [5:0] vc_req_valid;
  logic [5:0] vc_is_tail;
  logic       sa_grant;
  logic [2:0] sel;
  logic       sel_valid;
  logic [5:0] vc_pop;
  logic       locked;

  int n_checks;
  int n_errors;

  typedef struct {
    logic       rst_n;
    logic [5:0] valid;
    logic [5:0] tail;
    logic       grant;
    logic [2:0] e_sel;
    logic       e_sv;
    logic [5:0] e_pop;
    logic       e_lk;
  } vec_t;

  vec_t vecs[$];

  vc_sel_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vc_req_valid (vc_req_valid),
    .vc_is_tail   (vc_is_tail),
    .sa_grant     (sa_grant),
    .sel          (sel),
    .sel_valid    (sel_valid),
    .vc_pop       (vc_pop),
    .locked       (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [5:0] v, input logic [5:0] t, input logic g,
                     input logic [2:0] es, input logic esv, input logic [5:0] ep, input logic el);
    vec_t x;
    x.rst_n = r; x.valid = v; x.tail = t; x.grant = g;
    x.e_sel = es; x.e_sv = esv; x.e_pop = ep; x.e_lk = el;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] es, input logic esv,
                          input logic [5:0] ep, input logic el);
    chk({tag, " sel"},       {5'd0, sel},       {5'd0, es});
    chk({tag, " sel_valid"}, {7'd0, sel_valid}, {7'd0, esv});
    chk({tag, " vc_pop"},    {2'd0, vc_pop},    {2'd0, ep});
    chk({tag, " locked"},    {7'd0, locked},    {7'd0, el});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    vc_req_valid = '0;
    vc_is_tail = '0;
    sa_grant = 1'b0;

    // Reset state, held across edges.
    add(0, 6'b000000, 6'b000000, 0, 0, 0, 6'b000000, 0);
    add(0, 6'b000100, 6'b000100, 1, 0, 0, 6'b000000, 0);
    // Single request: sel=2 one cycle later, tail grant pops and returns to IDLE.
    add(1, 6'b000100, 6'b000100, 0, 0, 0, 6'b000000, 0);
    add(1, 6'b000100, 6'b000100, 1, 2, 1, 6'b000100, 0);
    add(1, 6'b000000, 6'b000000, 0, 2, 0, 6'b000000, 0);
    // Round robin from reset: grant in IDLE is ignored, then 0..5,0.
    add(0, 6'b000000, 6'b000000, 0, 0, 0, 6'b000000, 0);
    add(1, 6'b111111, 6'b111111, 1, 0, 0, 6'b000000, 0);
    for (int k = 0; k < 6; k++) begin
      add(1, 6'b111111, 6'b111111, 1, 3'(k), 1, 6'(1 << k), 0);
    end
    add(1, 6'b111111, 6'b111111, 1, 0, 1, 6'b000001, 0);
    add(1, 6'b000000, 6'b000000, 0, 1, 0, 6'b000000, 0);
    // Packet lock on VC1 (3 flits, 2-cycle bubble), VC3 waiting.
    add(1, 6'b001010, 6'b001000, 1, 1, 0, 6'b000000, 0);
    add(1, 6'b001010, 6'b001000, 1, 1, 1, 6'b000010, 0);
    add(1, 6'b001000, 6'b001000, 1, 1, 0, 6'b000000, 1);
    add(1, 6'b001000, 6'b001000, 1, 1, 0, 6'b000000, 1);
    add(1, 6'b001010, 6'b001000, 1, 1, 1, 6'b000010, 1);
    add(1, 6'b001010, 6'b001010, 1, 1, 1, 6'b000010, 1);
    add(1, 6'b001000, 6'b001000, 1, 3, 1, 6'b001000, 0);
    add(1, 6'b000000, 6'b000000, 0, 3, 0, 6'b000000, 0);
    // Starvation: VC0/VC4 without grants rotate every 8 cycles.
    add(0, 6'b000000, 6'b000000, 0, 0, 0, 6'b000000, 0);
    add(1, 6'b010001, 6'b000000, 0, 0, 0, 6'b000000, 0);
    for (int k = 0; k < 8; k++) add(1, 6'b010001, 6'b000000, 0, 0, 1, 6'b000000, 0);
    for (int k = 0; k < 8; k++) add(1, 6'b010001, 6'b000000, 0, 4, 1, 6'b000000, 0);
    // Only VC0 left: held well beyond the wait limit.
    for (int k = 0; k < 13; k++) add(1, 6'b000001, 6'b000000, 0, 0, 1, 6'b000000, 0);
    add(1, 6'b000001, 6'b000001, 1, 0, 1, 6'b000001, 0);
    add(1, 6'b000000, 6'b000000, 0, 0, 0, 6'b000000, 0);
    // Pointer wrap: VC4 tail grant puts rr_ptr at 5, then 5 wins, then 0.
    add(1, 6'b010000, 6'b010000, 0, 0, 0, 6'b000000, 0);
    add(1, 6'b010000, 6'b010000, 1, 4, 1, 6'b010000, 0);
    add(1, 6'b100001, 6'b100001, 0, 4, 0, 6'b000000, 0);
    add(1, 6'b100001, 6'b100001, 1, 5, 1, 6'b100000, 0);
    add(1, 6'b000001, 6'b000001, 1, 0, 1, 6'b000001, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst_n        = vecs[i].rst_n;
      vc_req_valid = vecs[i].valid;
      vc_is_tail   = vecs[i].tail;
      sa_grant     = vecs[i].grant;
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_sv, vecs[i].e_pop, vecs[i].e_lk);
    end

    // Asynchronous reset in the middle of a locked packet on VC2.
    @(posedge clk);
    #1;
    vc_req_valid = 6'b000100;
    vc_is_tail   = 6'b000000;
    sa_grant     = 1'b0;
    @(posedge clk);
    #1;
    sa_grant = 1'b1;
    @(negedge clk);
    chk_outs("lock_head", 3'd2, 1'b1, 6'b000100, 1'b0);
    @(posedge clk);
    #1;
    sa_grant = 1'b0;
    @(negedge clk);
    chk_outs("lock_held", 3'd2, 1'b1, 6'b000000, 1'b1);
    #2;
    rst_n    = 1'b0;
    sa_grant = 1'b1;
    #1;
    chk_outs("mid_rst", 3'd0, 1'b0, 6'b000000, 1'b0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    sa_grant = 1'b0;
    @(posedge clk);
    #1;
    chk_outs("post_rst", 3'd2, 1'b1, 6'b000000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vc_sel_arbiter.md
Name: vc_sel_arbiter

Overview:
- Per-input-port scheduler that drives the select of the 6-to-1 per-VC request mux in front of the switch allocator.
- Round-robins among VCs with a pending head flit and holds the selection stable until the switch allocator grants.
- Locks onto a VC for the remaining flits of a multi-flit packet.
- Rotates away from a VC that waits too long without a grant, so one blocked VC cannot stall the port.

Parameters:
- NUM_VC, 6: number of VCs per input port; must match the mux fan-in.
- VC_INDEX_WIDTH, 3: width of sel; ceil(log2(NUM_VC)).
- LOCK_PKT, 1: 1 = hold the VC until its tail flit is granted; 0 = re-arbitrate after every grant.
- MAX_WAIT, 8: number of REQ cycles without a grant before rotating. 0 disables rotation.
- WAIT_W, 4: counter width; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous, active-low reset.
- vc_req_valid, input, NUM_VC: VC i holds a buffered flit with a non-zero output-port request.
- vc_is_tail, input, NUM_VC: the front flit of VC i is a tail or single-flit packet.
- sa_grant, input, 1: switch allocator granted the currently selected request this cycle.
- sel, output, VC_INDEX_WIDTH: registered mux select. Always in the range 0..NUM_VC-1.
- sel_valid, output, 1: sel points at a valid request to be presented to the switch allocator.
- vc_pop, output, NUM_VC: one-hot dequeue pulse to the VC buffers.
- locked, output, 1: arbiter is in LOCK state.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, sel=0, rr_ptr=0, wait_cnt=0.
  - sel_valid=0, vc_pop=0, locked=0.
- Combinational outputs:
  - sel_valid = (state!=IDLE) & vc_req_valid[sel].
  - vc_pop = onehot(sel) & {NUM_VC{sa_grant & sel_valid}}.
  - sa_grant is ignored whenever sel_valid=0.
- pick(p): first index i with vc_req_valid[i]=1, searching from p upward and wrapping modulo NUM_VC. Evaluated only when vc_req_valid is non-zero.
- IDLE:
  - If any vc_req_valid: sel<=pick(rr_ptr), go to REQ, wait_cnt<=0.
  - Latency from a request appearing to sel_valid=1 is 1 cycle.
- REQ, on a grant that is a tail, or any grant with LOCK_PKT=0:
  - rr_ptr<=sel+1, wrapping NUM_VC-1 to 0.
  - The just-popped VC is excluded from the next pick.
  - If any other VC is valid: sel<=pick(sel+1), stay in REQ, wait_cnt<=0.
  - Otherwise go to IDLE; sel is held.
- REQ, on a grant that is not a tail with LOCK_PKT=1: go to LOCK, sel held.
- REQ, no grant, vc_req_valid[sel]=1:
  - wait_cnt increments.
  - If wait_cnt==MAX_WAIT-1 and some other VC is valid: sel<=pick(sel+1), wait_cnt<=0, rr_ptr is unchanged.
  - If no other VC is valid, wait_cnt saturates at MAX_WAIT-1 and sel is held.
- REQ, no grant, vc_req_valid[sel]=0: go to IDLE, sel held, wait_cnt<=0.
- LOCK:
  - sel is held; no rotation and no wait counting.
  - A bubble (vc_req_valid[sel]=0) keeps the arbiter in LOCK with sel_valid=0.
  - A grant with vc_is_tail[sel]=1 follows the REQ tail-grant rule above.
  - A grant with vc_is_tail[sel]=0 stays in LOCK.
- Output stability: sel changes only on a clock edge, never mid-cycle. At most one vc_pop bit is set per cycle.
- Reset mid-packet clears the lock immediately. The VC buffers are reset by the same rst_n.

Decomposition:
- Shared package/header (global.vh): NUM_PORT, NUM_VC, VC_INDEX_WIDTH, and state encodings ST_IDLE=2'd0, ST_REQ=2'd1, ST_LOCK=2'd2.
- One natural sub-module, rr_pick_vc: combinational wrap-around priority pick.
  - Inputs: valid vector, start pointer, exclude mask.
  - Outputs: index and found.

Test Plan:
- Reset and single request:
  - Hold rst_n=0, then release; vc_req_valid=6'b000100.
  - Required: sel=2 and sel_valid=1 one cycle later.
  - Required: sa_grant=1 with vc_is_tail[2]=1 gives vc_pop=6'b000100, then IDLE.
- Round-robin fairness:
  - vc_req_valid=6'b111111, vc_is_tail all 1, sa_grant=1 every cycle.
  - Required: sel sequence 0,1,2,3,4,5,0 with exactly one vc_pop bit per cycle.
- Packet lock (LOCK_PKT=1):
  - VC1 carries a 3-flit packet, VC3 is valid, grants every cycle.
  - Required: sel=1 for 3 grants, locked=1 after the head grant, then sel=3.
  - Bubble check: dropping vc_req_valid[1] for 2 cycles mid-packet keeps sel=1 with sel_valid=0.
- Starvation rotation (MAX_WAIT=8):
  - VC0 and VC4 valid, no sa_grant.
  - Required: sel switches 0→4 after 8 cycles and 4→0 after 8 more.
  - Required: with only VC0 valid, sel=0 is held indefinitely.
- Wrap and reset mid-operation:
  - Start with rr_ptr=5 and vc_req_valid=6'b100001; required: sel=5, then 0 after a tail grant.
  - Pulse rst_n=0 asynchronously while in LOCK.
  - Required: locked=0, sel=0 and sel_valid=0 immediately, with no vc_pop.
